// File: rtl/oflow_buffer_fsm_read.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_buffer_fsm_read
//  Description : Reads one set of history-buffer lines and hands them to the
//                PEs one line per read_new_line request.
//  Revision    : 1.0 - initial release
// ============================================================================
module oflow_buffer_fsm_read #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 200,
    parameter int LINES_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_read,
    input  logic               read_new_line,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LINES_W-1:0] num_lines,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               line_valid,
    output logic               done_read,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ      = 2'd1,
        ST_WAIT_LINE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LINES_W-1:0]   r_num_lines;
    logic [LINES_W-1:0]   w_num_lines_nxt;
    logic [LINES_W-1:0]   r_lines_done;
    logic [LINES_W-1:0]   w_lines_done_nxt;
    logic                 w_rd_en_nxt;
    logic [ADDR_W-1:0]    w_rd_addr_nxt;
    logic                 w_line_valid_nxt;
    logic                 w_done_read_nxt;
    logic                 w_busy_nxt;
    logic [ADDR_W-1:0]    w_addr_inc;

    // Buffer addresses run 0..DEPTH-1 and wrap rather than overflow the field.
    assign w_addr_inc = (rd_addr == c_last_addr) ? '0 : rd_addr + ADDR_W'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_num_lines_nxt  = r_num_lines;
        w_lines_done_nxt = r_lines_done;
        w_rd_en_nxt      = 1'b0;
        w_rd_addr_nxt    = rd_addr;
        w_line_valid_nxt = 1'b0;
        w_done_read_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_read) begin
                    w_num_lines_nxt  = num_lines;
                    w_lines_done_nxt = '0;
                    if (num_lines != '0) begin
                        w_state_nxt   = ST_READ;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = base_addr;
                    end else begin
                        w_state_nxt     = ST_DONE;
                        w_done_read_nxt = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Memory returns data one cycle after the strobe.
                w_state_nxt      = ST_WAIT_LINE;
                w_line_valid_nxt = 1'b1;
                w_lines_done_nxt = r_lines_done + LINES_W'(1);
            end
            ST_WAIT_LINE: begin
                if (read_new_line) begin
                    if (r_lines_done < r_num_lines) begin
                        w_state_nxt   = ST_READ;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = w_addr_inc;
                    end else begin
                        w_state_nxt     = ST_DONE;
                        w_done_read_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_num_lines  <= '0;
            r_lines_done <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            line_valid   <= 1'b0;
            done_read    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_num_lines  <= w_num_lines_nxt;
            r_lines_done <= w_lines_done_nxt;
            rd_en        <= w_rd_en_nxt;
            rd_addr      <= w_rd_addr_nxt;
            line_valid   <= w_line_valid_nxt;
            done_read    <= w_done_read_nxt;
            busy         <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oflow_buffer_fsm_read.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oflow_buffer_fsm_read
//  Description : Self-checking bench; expected read addresses are queued as
//                stimulus is driven and popped when the DUT strobes rd_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_buffer_fsm_read;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 200;
    localparam int LINES_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_read;
    logic               read_new_line;
    logic [ADDR_W-1:0]  base_addr;
    logic [LINES_W-1:0] num_lines;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               line_valid;
    logic               done_read;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic              mon_en     = 1'b0;
    logic              prev_rd_en = 1'b0;

    always #5 clk = ~clk;

    oflow_buffer_fsm_read #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LINES_W(LINES_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_read   (start_read),
        .read_new_line(read_new_line),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .line_valid   (line_valid),
        .done_read    (done_read),
        .busy         (busy)
    );

    // Scoreboard: every strobe must match the next queued address, and
    // line_valid must trail each strobe by exactly one cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (line_valid !== prev_rd_en) begin
                errors++;
                $display("FAIL line_valid_latency: got %b expected %b at %0t", line_valid, prev_rd_en, $time);
            end
            if (rd_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_en: got rd_en=1 addr=%0d expected no read at %0t", rd_addr, $time);
                end else begin
                    exp_addr = exp_q.pop_front();
                    if (rd_addr !== exp_addr) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d expected %0d at %0t", rd_addr, exp_addr, $time);
                    end
                end
            end
        end
        prev_rd_en = (rd_en === 1'b1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_set(input logic [ADDR_W-1:0] b, input logic [LINES_W-1:0] n);
        start_read = 1'b1;
        base_addr  = b;
        num_lines  = n;
        @(posedge clk);
        #1;
        start_read = 1'b0;
    endtask

    task automatic pulse_rnl();
        read_new_line = 1'b1;
        @(posedge clk);
        #1;
        read_new_line = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(3);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid: got %b expected 0", line_valid); end
        checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL reset_done_read: got %b expected 0", done_read); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        wait_cycles(1);
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(10 + i));
        start_set(8'd10, 4'd4);
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL basic_first_rd_en: got %b expected 1", rd_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            wait_cycles(10);
            checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b expected 0 (pulse %0d)", done_read, i); end
            pulse_rnl();
        end
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done_read); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_done_busy: got %b expected 1", busy); end
        wait_cycles(1);
        checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done_read); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        exp_q.push_back(8'd198);
        exp_q.push_back(8'd199);
        exp_q.push_back(8'd0);
        start_set(8'd198, 4'd3);
        for (int i = 0; i < 3; i++) begin
            wait_cycles(4);
            pulse_rnl();
        end
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", done_read); end
        wait_cycles(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_empty();
        start_set(8'd50, 4'd0);
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL empty_done: got %b expected 1", done_read); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b expected 1", busy); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en: got %b expected 0", rd_en); end
        wait_cycles(1);
        checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL empty_done_width: got %b expected 0", done_read); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_idle_busy: got %b expected 0", busy); end
        wait_cycles(2);
    endtask

    task automatic test_dropped();
        exp_q.push_back(8'd20);
        exp_q.push_back(8'd21);
        start_set(8'd20, 4'd2);
        wait_cycles(3);
        // start_read with new values lands in WAIT_LINE alongside a valid request
        start_read    = 1'b1;
        base_addr     = 8'd100;
        num_lines     = 4'd7;
        read_new_line = 1'b1;
        @(posedge clk);
        #1;
        start_read    = 1'b0;
        read_new_line = 1'b0;
        checks++; if (rd_addr !== 8'd21) begin errors++; $display("FAIL drop_start_addr: got %0d expected 21", rd_addr); end
        pulse_rnl();
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL drop_rnl_queued: got done_read %b expected 0", done_read); end
        end
        pulse_rnl();
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL drop_num_kept: got done_read %b expected 1", done_read); end
        wait_cycles(2);
        pulse_rnl();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_rnl_busy: got %b expected 0", busy); end
        wait_cycles(2);
        exp_q.push_back(8'd30);
        start_read    = 1'b1;
        base_addr     = 8'd30;
        num_lines     = 4'd1;
        read_new_line = 1'b1;
        @(posedge clk);
        #1;
        start_read    = 1'b0;
        read_new_line = 1'b0;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL idle_both_rd_en: got %b expected 1", rd_en); end
        wait_cycles(3);
        pulse_rnl();
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL idle_both_done: got %b expected 1", done_read); end
        wait_cycles(2);
    endtask

    task automatic test_mid_reset();
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd41);
        start_set(8'd40, 4'd3);
        wait_cycles(3);
        pulse_rnl();
        wait_cycles(3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL midrst_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done_read); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            checks++; if (done_read !== 1'b0) begin errors++; $display("FAIL midrst_late_done: got %b expected 0", done_read); end
        end
        exp_q.push_back(8'd5);
        start_set(8'd5, 4'd1);
        checks++; if (rd_addr !== 8'd5) begin errors++; $display("FAIL midrst_restart_addr: got %0d expected 5", rd_addr); end
        wait_cycles(3);
        pulse_rnl();
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL midrst_restart_done: got %b expected 1", done_read); end
        wait_cycles(2);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'd60);
        start_set(8'd60, 4'd1);
        wait_cycles(2);
        pulse_rnl();
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done_read); end
        wait_cycles(1);
        exp_q.push_back(8'd70);
        exp_q.push_back(8'd71);
        start_set(8'd70, 4'd2);
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL b2b_rd_en: got %b expected 1", rd_en); end
        checks++; if (rd_addr !== 8'd70) begin errors++; $display("FAIL b2b_rd_addr: got %0d expected 70", rd_addr); end
        wait_cycles(3);
        pulse_rnl();
        wait_cycles(3);
        pulse_rnl();
        checks++; if (done_read !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", done_read); end
        wait_cycles(2);
    endtask

    initial begin
        reset         = 1'b1;
        start_read    = 1'b0;
        read_new_line = 1'b0;
        base_addr     = '0;
        num_lines     = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_dropped();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
